// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - DataMemory arbiter between pipeline MEM stage and debug port
// The pipeline wins by default; the starve counter and lock mode guarantee debug access.

module dmem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int BURST_MAX    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] p_addr,
   input  logic [DATA_W-1:0] p_wdata,
   input  logic              p_mem_read,
   input  logic              p_mem_write,
   output logic [DATA_W-1:0] p_rdata,
   output logic              p_stall,
   input  logic              d_valid,
   input  logic              d_we,
   input  logic              d_lock,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ready,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic [1:0]        owner,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int BW = $clog2(BURST_MAX + 1);
   localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT);
   localparam logic [BW-1:0] BURST_TOP  = BW'(BURST_MAX);

   typedef enum logic [1:0] {
      OWN_IDLE = 2'd0,
      OWN_PIPE = 2'd1,
      OWN_DBG  = 2'd2
   } owner_e;

   owner_e            owner_q, owner_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic [BW-1:0]     burst_q, burst_d;
   logic              rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic p_req;
   logic grant_d;
   logic d_go;
   logic p_go;

   always_comb begin
      p_req   = p_mem_read | p_mem_write;
      grant_d = d_valid & (~p_req
                           | (starve_q >= STARVE_TOP)
                           | ((owner_q == OWN_DBG) & d_lock & (burst_q < BURST_TOP)));
      // Reset blocks every memory side effect, whichever port is asking.
      d_go    = grant_d & ~rst;
      p_go    = p_req & ~grant_d & ~rst;
   end

   always_comb begin
      mem_addr  = d_go ? d_addr  : p_addr;
      mem_wdata = d_go ? d_wdata : p_wdata;
      mem_read  = d_go ? ~d_we : (p_go & p_mem_read);
      mem_write = d_go ?  d_we : (p_go & p_mem_write);
      d_ready   = d_go;
      p_stall   = d_go & p_req;
      p_rdata   = mem_rdata;
      d_rvalid  = rvalid_q;
      d_rdata   = rdata_q;
      owner     = owner_q;
   end

   always_comb begin
      owner_d = OWN_IDLE;
      if (grant_d)
         owner_d = OWN_DBG;
      else if (p_req)
         owner_d = OWN_PIPE;

      starve_d = '0;
      if (d_valid && !grant_d)
         starve_d = (starve_q == STARVE_TOP) ? starve_q : starve_q + 1'b1;

      // A saturated burst count only clears when D loses a cycle, so lock re-entry waits for zero.
      burst_d = '0;
      if (grant_d && d_lock)
         burst_d = (burst_q == BURST_TOP) ? burst_q : burst_q + 1'b1;

      rvalid_d = grant_d & ~d_we;
      rdata_d  = rvalid_d ? mem_rdata : rdata_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q  <= OWN_IDLE;
         starve_q <= '0;
         burst_q  <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         owner_q  <= owner_d;
         starve_q <= starve_d;
         burst_q  <= burst_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
// A small word-addressed memory model stands in for DataMemory.

module tb_dmem_arbiter;

   logic        clk;
   logic        rst;
   logic [31:0] p_addr, p_wdata, p_rdata;
   logic        p_mem_read, p_mem_write, p_stall;
   logic        d_valid, d_we, d_lock, d_ready, d_rvalid;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [1:0]  owner;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_read, mem_write;

   logic [31:0] mem [0:63];

   int errors = 0;
   int checks = 0;

   dmem_arbiter dut (
      .clk(clk), .rst(rst),
      .p_addr(p_addr), .p_wdata(p_wdata), .p_mem_read(p_mem_read),
      .p_mem_write(p_mem_write), .p_rdata(p_rdata), .p_stall(p_stall),
      .d_valid(d_valid), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_ready(d_ready), .d_rvalid(d_rvalid),
      .d_rdata(d_rdata), .owner(owner),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
      .mem_write(mem_write), .mem_rdata(mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign mem_rdata = mem[mem_addr[7:2]];

   always @(posedge clk)
      if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   logic [17:0] pat;
   int          beat;
   logic [31:0] r11, r12;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = '0;
      rst = 1'b1;
      p_addr = 32'd20; p_wdata = '0; p_mem_read = 1'b1; p_mem_write = 1'b0;
      d_valid = 1'b1; d_we = 1'b1; d_lock = 1'b0; d_addr = 32'd40; d_wdata = 32'd77;

      // Requests present during reset must be ignored.
      next_cycle;
      next_cycle;
      #1;
      check("rst_d_ready", {31'd0, d_ready}, 32'd0);
      check("rst_p_stall", {31'd0, p_stall}, 32'd0);
      check("rst_mem_read", {31'd0, mem_read}, 32'd0);
      check("rst_mem_write", {31'd0, mem_write}, 32'd0);
      next_cycle;
      check("rst_owner", {30'd0, owner}, 32'd0);
      check("rst_rvalid", {31'd0, d_rvalid}, 32'd0);

      // D alone: write 5 to 20, then read it back.
      rst = 1'b0;
      p_mem_read = 1'b0;
      d_valid = 1'b1; d_we = 1'b1; d_addr = 32'd20; d_wdata = 32'd5;
      #1;
      check("dw_ready", {31'd0, d_ready}, 32'd1);
      check("dw_mem_write", {31'd0, mem_write}, 32'd1);
      check("dw_mem_addr", mem_addr, 32'd20);
      next_cycle;
      check("dw_owner", {30'd0, owner}, 32'd2);
      d_we = 1'b0;
      #1;
      check("dr_ready", {31'd0, d_ready}, 32'd1);
      check("dr_mem_read", {31'd0, mem_read}, 32'd1);
      next_cycle;
      check("dr_rvalid", {31'd0, d_rvalid}, 32'd1);
      check("dr_rdata", d_rdata, 32'd5);

      // Reset during a D read discards the response.
      rst = 1'b1;
      #1;
      check("rr_d_ready", {31'd0, d_ready}, 32'd0);
      next_cycle;
      check("rr_rvalid", {31'd0, d_rvalid}, 32'd0);
      check("rr_owner", {30'd0, owner}, 32'd0);
      rst = 1'b0;
      d_valid = 1'b0;
      p_mem_read = 1'b1; p_addr = 32'd20;
      #1;
      check("rr_lw_stall", {31'd0, p_stall}, 32'd0);
      check("rr_lw_mem_read", {31'd0, mem_read}, 32'd1);
      check("rr_lw_rdata", p_rdata, 32'd5);

      // Contention: P wins four cycles, D forced on the fifth.
      for (int i = 0; i < 4; i++) begin
         next_cycle;
         d_valid = 1'b1; d_we = 1'b0; d_addr = 32'd24;
         #1;
         check("ct_d_ready_p", {31'd0, d_ready}, 32'd0);
         check("ct_p_stall_p", {31'd0, p_stall}, 32'd0);
      end
      next_cycle;
      #1;
      check("ct_d_ready_d", {31'd0, d_ready}, 32'd1);
      check("ct_p_stall_d", {31'd0, p_stall}, 32'd1);
      check("ct_mem_addr_d", mem_addr, 32'd24);
      next_cycle;
      d_valid = 1'b0;
      #1;
      check("ct_resume_stall", {31'd0, p_stall}, 32'd0);
      check("ct_resume_read", {31'd0, mem_read}, 32'd1);
      check("ct_resume_addr", mem_addr, 32'd20);
      check("ct_rvalid", {31'd0, d_rvalid}, 32'd1);
      check("ct_rdata", d_rdata, 32'd0);

      // Lock: 4 P, 8 locked D beats, 4 P (starve refill), then 2 more D beats.
      pat = 18'b11_0000_11111111_0000;
      beat = 0;
      for (int c = 0; c < 18; c++) begin
         next_cycle;
         d_valid = 1'b1; d_we = 1'b1; d_lock = 1'b1;
         d_addr = 32'd32 + 32'(4 * beat); d_wdata = 32'd100 + 32'(beat);
         #1;
         check("lk_d_ready", {31'd0, d_ready}, {31'd0, pat[c]});
         check("lk_p_stall", {31'd0, p_stall}, {31'd0, pat[c]});
         check("lk_mem_write", {31'd0, mem_write}, {31'd0, pat[c]});
         if (pat[c]) beat++;
      end
      next_cycle;
      p_mem_read = 1'b0;
      d_valid = 1'b1; d_we = 1'b0; d_lock = 1'b0; d_addr = 32'd68;
      next_cycle;
      check("lk_last_rvalid", {31'd0, d_rvalid}, 32'd1);
      check("lk_last_rdata", d_rdata, 32'd109);

      // Pipeline program: clear 20, then sw 5 and D read of 20 in the same cycle.
      d_we = 1'b1; d_addr = 32'd20; d_wdata = 32'd0;
      next_cycle;
      p_mem_write = 1'b1; p_addr = 32'd20; p_wdata = 32'd5;
      d_we = 1'b0; d_addr = 32'd20;
      #1;
      check("pg_sw_d_ready", {31'd0, d_ready}, 32'd0);
      check("pg_sw_write", {31'd0, mem_write}, 32'd1);
      check("pg_sw_wdata", mem_wdata, 32'd5);
      next_cycle;
      p_mem_write = 1'b0;
      #1;
      check("pg_dr_ready", {31'd0, d_ready}, 32'd1);
      check("pg_dr_read", {31'd0, mem_read}, 32'd1);
      next_cycle;
      check("pg_dr_rvalid", {31'd0, d_rvalid}, 32'd1);
      check("pg_dr_rdata", d_rdata, 32'd5);
      d_valid = 1'b0;
      p_mem_read = 1'b1; p_addr = 32'd20;
      #1;
      check("pg_lw_rdata", p_rdata, 32'd5);
      r11 = p_rdata;
      r12 = r11 + 32'd5;
      check("pg_add", r12, 32'd10);
      next_cycle;
      p_mem_read = 1'b0; p_mem_write = 1'b1; p_addr = 32'd24; p_wdata = r12;
      next_cycle;
      p_mem_write = 1'b0;
      d_valid = 1'b1; d_we = 1'b0; d_addr = 32'd24;
      #1;
      check("pg_dr2_ready", {31'd0, d_ready}, 32'd1);
      next_cycle;
      d_valid = 1'b0;
      check("pg_dr2_rdata", d_rdata, 32'd10);

      // Idle.
      #1;
      check("id_mem_read", {31'd0, mem_read}, 32'd0);
      check("id_mem_write", {31'd0, mem_write}, 32'd0);
      check("id_d_ready", {31'd0, d_ready}, 32'd0);
      next_cycle;
      check("id_owner", {30'd0, owner}, 32'd0);
      check("id_rvalid", {31'd0, d_rvalid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
